// File: rtl/div_seq.sv
// Sequential restoring divider: 4-bit dividend / 2-bit divisor.
// One quotient bit per cycle, MSB first, four CALC cycles per division.
// A zero divisor skips the CALC loop and reports div0 with Q saturated to all ones.
module div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [1:0] B,
  output logic [3:0] Q,
  output logic [1:0] R,
  output logic       busy,
  output logic       done,
  output logic       div0
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [2:0] rem, rem_nx;
  logic [3:0] sr, sr_nx;      // dividend shifts out of the top, quotient shifts in at the bottom
  logic [1:0] dvs, dvs_nx;
  logic [3:0] q_nx;
  logic [1:0] r_nx;
  logic       busy_nx, done_nx, div0_nx;

  logic [2:0] part;
  logic       ge;

  // Partial remainder for this step: old remainder with the next dividend bit appended.
  assign part = {rem[1:0], sr[3]};
  assign ge   = (part >= {1'b0, dvs});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath updates; done defaults low so it only ever pulses for one cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rem_nx   = rem;
    sr_nx    = sr;
    dvs_nx   = dvs;
    q_nx     = Q;
    r_nx     = R;
    busy_nx  = busy;
    done_nx  = 1'b0;
    div0_nx  = div0;
    case (state)
      IDLE: begin
        if (start) begin
          dvs_nx = B;
          sr_nx  = A;
          cnt_nx = 2'd0;
          rem_nx = 3'd0;
          if (B == 2'd0) begin
            q_nx     = 4'hF;
            r_nx     = 2'b00;
            div0_nx  = 1'b1;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = DONE;
          end else begin
            busy_nx  = 1'b1;
            state_nx = CALC;
          end
        end
      end
      CALC: begin
        rem_nx = ge ? (part - {1'b0, dvs}) : part;
        sr_nx  = {sr[2:0], ge};
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) begin
          q_nx     = {sr[2:0], ge};
          r_nx     = rem_nx[1:0];
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          div0_nx  = 1'b0;
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and output registers; reset wins over everything, aborting any division.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      rem  <= 3'd0;
      sr   <= 4'd0;
      dvs  <= 2'd0;
      Q    <= 4'd0;
      R    <= 2'd0;
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      rem  <= rem_nx;
      sr   <= sr_nx;
      dvs  <= dvs_nx;
      Q    <= q_nx;
      R    <= r_nx;
      busy <= busy_nx;
      done <= done_nx;
      div0 <= div0_nx;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expectations queued at accepted start, checked on done.
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] A, Q;
  logic [1:0] B, R;
  logic       busy, done, div0;

  div_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [1:0] b;
    logic [3:0] q;
    logic [1:0] r;
    logic       d0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int dones  = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 2'd0) begin
      e.q = 4'hF; e.r = 2'd0; e.d0 = 1'b1;
    end else begin
      e.q = 4'(int'(a) / int'(b));
      e.r = 2'(int'(a) % int'(b));
      e.d0 = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      dones++;
      check("busy_with_done", int'(busy), 0);
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("Q", int'(Q), int'(e.q));
        check("R", int'(R), int'(e.r));
        check("div0", int'(div0), int'(e.d0));
        if (!e.d0) begin
          check("inv_qb_r", int'(Q) * int'(e.b) + int'(R), int'(e.a));
          check("r_lt_b", int'(R < e.b), 1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("idle_timeout", n, 0);
  endtask

  // One division from IDLE; checks latency, busy shape and output hold after DONE.
  task automatic do_div(input logic [3:0] a, input logic [1:0] b, input bit full);
    exp_t e;
    int lat;
    wait_idle();
    e = model(a, b);
    start = 1'b1; A = a; B = b;
    sb.push_back(e);
    @(negedge clk);                      // edge k passed
    start = 1'b0; A = 4'($urandom); B = 2'($urandom);
    if (full) check("busy_after_k", int'(busy), int'(b != 2'd0));
    lat = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (full && lat <= 3 && b != 2'd0) check("busy_calc", int'(busy), 1);
    end
    if (full) check("latency", lat, (b == 2'd0) ? 0 : 4);
    else if (lat >= 8) check("done_timeout", lat, 4);
    @(negedge clk);
    if (full) begin
      check("done_pulse_1cyc", int'(done), 0);
      check("Q_hold", int'(Q), int'(e.q));
      check("R_hold", int'(R), int'(e.r));
      check("div0_hold", int'(div0), int'(e.d0));
    end
  endtask

  initial begin
    int d_before, n;
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_Q", int'(Q), 0);
    check("rst_R", int'(R), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_div0", int'(div0), 0);
    // start with rst high must not be accepted
    start = 1'b1; A = 4'd5; B = 2'd1;
    @(negedge clk);
    check("rst_blocks_start", int'(busy), 0);
    start = 1'b0; rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_done_after_rst_start", dones, 0);

    do_div(4'd13, 2'd3, 1'b1);
    do_div(4'd15, 2'd1, 1'b1);
    do_div(4'd2,  2'd3, 1'b1);
    do_div(4'd9,  2'd0, 1'b1);

    // start during CALC is ignored, and A/B changes are not seen
    wait_idle();
    d_before = dones;
    start = 1'b1; A = 4'd7; B = 2'd2;
    sb.push_back(model(4'd7, 2'd2));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 4'd15; B = 2'd1;
    @(negedge clk);
    start = 1'b0; A = 4'd0; B = 2'd0;
    repeat (8) @(negedge clk);
    check("one_done_ignore_start", dones - d_before, 1);
    check("sb_empty_ignore", sb.size(), 0);

    // reset mid-CALC aborts without a done pulse
    wait_idle();
    d_before = dones;
    start = 1'b1; A = 4'd13; B = 2'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_Q", int'(Q), 0);
    check("abort_R", int'(R), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_div0", int'(div0), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", dones - d_before, 0);
    do_div(4'd11, 2'd2, 1'b1);

    // exhaustive sweep, back-to-back from IDLE
    d_before = dones;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 4; b++)
        do_div(4'(a), 2'(b), 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sweep_done_count", dones - d_before, 64);
    check("sweep_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
